// File: rtl/parallel_io_pkg.sv
// Register offsets and bus types shared by the parallel input and output ports.
package parallel_io_pkg;

    typedef logic [31:0] word_t;

    localparam logic [3:0] PIN_DATA   = 4'h0;
    localparam logic [3:0] PIN_RISE   = 4'h4;
    localparam logic [3:0] PIN_FALL   = 4'h8;
    localparam logic [3:0] PIN_IRQ_EN = 4'hC;

    // Expands the four byte enables into a 32-bit bit mask.
    function automatic word_t lane_mask(input logic [3:0] wmask);
        return {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
    endfunction

endpackage

// File: rtl/input_synchronizer.sv
// Multi-flop synchroniser for asynchronous input pins; every stage resets to 0.
module input_synchronizer #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= async_in;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/parallel_input.sv
// Memory-mapped 32-bit parallel input port with sticky edge flags.
// Optional interrupt enable register and irq output under macro PARALLEL_INPUT_IRQ_EN.
module parallel_input
    import parallel_io_pkg::*;
#(
    parameter word_t ADDR        = 32'hf010,
    parameter int    SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        wen,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        active,
    input  logic [31:0] io,
    output logic        irq
);

    localparam int PRIME_CYCLES = SYNC_STAGES + 1;
    localparam int CNT_W        = $clog2(PRIME_CYCLES + 1);

    logic [CNT_W-1:0] prime_cnt;
    logic             primed;
    word_t            sync_level;
    word_t            history;
    word_t            rise_edge;
    word_t            fall_edge;
    word_t            rise_flags;
    word_t            fall_flags;
    word_t            bit_mask;
    word_t            rise_clear;
    word_t            fall_clear;
    word_t            read_word;
    logic [3:0]       offset;
    logic             wr_hit;
    logic             unused_addr_bits;

    assign active           = (addr[31:4] == ADDR[31:4]);
    assign offset           = {addr[3:2], 2'b00};
    assign wr_hit           = wen & active;
    assign bit_mask         = lane_mask(wmask);
    assign unused_addr_bits = ^addr[1:0];

    input_synchronizer #(
        .WIDTH  (32),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (io),
        .sync_out (sync_level)
    );

    // Hold off edge detection until the chain and history flop carry real pin levels.
    assign primed = (prime_cnt == CNT_W'(PRIME_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            prime_cnt <= '0;
            history   <= '0;
        end else begin
            if (!primed) begin
                prime_cnt <= prime_cnt + CNT_W'(1);
            end
            history <= sync_level;
        end
    end

    assign rise_edge  = primed ? (sync_level & ~history) : '0;
    assign fall_edge  = primed ? (~sync_level & history) : '0;
    assign rise_clear = (wr_hit && offset == PIN_RISE) ? (wdata & bit_mask) : '0;
    assign fall_clear = (wr_hit && offset == PIN_FALL) ? (wdata & bit_mask) : '0;

    // A new edge is ORed in after the clear so it is never lost to a concurrent W1C.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_flags <= '0;
            fall_flags <= '0;
        end else begin
            rise_flags <= (rise_flags & ~rise_clear) | rise_edge;
            fall_flags <= (fall_flags & ~fall_clear) | fall_edge;
        end
    end

`ifdef PARALLEL_INPUT_IRQ_EN
    word_t irq_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr_hit && offset == PIN_IRQ_EN) begin
                irq_en <= (irq_en & ~bit_mask) | (wdata & bit_mask);
            end
            irq <= |((rise_flags | fall_flags) & irq_en);
        end
    end
`else
    word_t irq_en;
    assign irq_en = '0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        read_word = '0;
        case (offset)
            PIN_DATA:   read_word = sync_level;
            PIN_RISE:   read_word = rise_flags;
            PIN_FALL:   read_word = fall_flags;
            PIN_IRQ_EN: read_word = irq_en;
            default:    read_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
            ready <= 1'b0;
        end else begin
            ready <= (ren | wen) & active;
            if (ren && active) begin
                rdata <= read_word;
            end
        end
    end

endmodule

// File: tb/tb_parallel_input.sv
// Table-driven bench for parallel_input plus directed multi-cycle sequences.
// Build with +define+PARALLEL_INPUT_IRQ_EN to exercise the interrupt path.
module tb_parallel_input;

    localparam logic [31:0] BASE = 32'hf010;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic        ren;
    logic [31:0] rdata;
    logic        ready;
    logic        active;
    logic [31:0] io;
    logic        irq;

    int total = 0;
    int bad   = 0;

    parallel_input #(
        .ADDR        (BASE),
        .SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wdata  (wdata),
        .wmask  (wmask),
        .wen    (wen),
        .ren    (ren),
        .rdata  (rdata),
        .ready  (ready),
        .active (active),
        .io     (io),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pins;
        int          waits;
        bit          is_write;
        logic [3:0]  off;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] data, output logic rdy);
        @(negedge clk);
        addr = a;
        ren  = 1'b1;
        @(negedge clk);
        ren  = 1'b0;
        data = rdata;
        rdy  = ready;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wmask = m;
        wen   = 1'b1;
        @(negedge clk);
        wen   = 1'b0;
    endtask

    task automatic bus_rw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          output logic [31:0] data, output logic rdy);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wmask = m;
        wen   = 1'b1;
        ren   = 1'b1;
        @(negedge clk);
        wen   = 1'b0;
        ren   = 1'b0;
        data  = rdata;
        rdy   = ready;
    endtask

    task automatic read_check(input string name, input logic [3:0] off, input logic [31:0] exp);
        logic [31:0] d;
        logic        r;
        bus_read(BASE + {28'h0, off}, d, r);
        checkOutput({name, " rdata"}, d, exp);
        checkOutput({name, " ready"}, {31'h0, r}, 32'h1);
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        io = v.pins;
        wait_cycles(v.waits);
        if (v.is_write) begin
            bus_write(BASE + {28'h0, v.off}, v.wd, v.wm);
        end else begin
            read_check($sformatf("vec%0d", idx), v.off, v.exp);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        r;

        rst = 1'b1; addr = '0; wdata = '0; wmask = '0; wen = 1'b0; ren = 1'b0;
        io  = 32'hFFFF_FFFF;

        //            pins           waits wr  off    wdata          wmask  expected
        vecs.push_back('{32'hFFFF_FFFF, 0, 1'b0, 4'h4, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{32'hFFFF_FFFF, 0, 1'b0, 4'h0, 32'h0,         4'h0, 32'hFFFF_FFFF});
        vecs.push_back('{32'hFFFF_FFFF, 0, 1'b0, 4'h8, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{32'h0000_0000, 5, 1'b0, 4'h8, 32'h0,         4'h0, 32'hFFFF_FFFF});
        vecs.push_back('{32'h0000_0000, 0, 1'b1, 4'h8, 32'hFFFF_FFFF, 4'hF, 32'h0});
        vecs.push_back('{32'h0000_0000, 0, 1'b0, 4'h8, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{32'h0000_0000, 0, 1'b0, 4'h0, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{32'h0000_00A5, 4, 1'b0, 4'h4, 32'h0,         4'h0, 32'h0000_00A5});
        vecs.push_back('{32'h0000_00A5, 0, 1'b0, 4'h8, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{32'h0000_00A5, 0, 1'b1, 4'h4, 32'h0000_0005, 4'hF, 32'h0});
        vecs.push_back('{32'h0000_00A5, 0, 1'b0, 4'h4, 32'h0,         4'h0, 32'h0000_00A0});
        vecs.push_back('{32'h0000_00A5, 0, 1'b0, 4'h0, 32'h0,         4'h0, 32'h0000_00A5});
        vecs.push_back('{32'h0000_00A5, 0, 1'b1, 4'h4, 32'hFFFF_FFFF, 4'hF, 32'h0});
        vecs.push_back('{32'h0000_0000, 5, 1'b1, 4'h8, 32'hFFFF_FFFF, 4'hF, 32'h0});
        vecs.push_back('{32'h0000_0000, 0, 1'b0, 4'h8, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{32'h0000_0000, 0, 1'b0, 4'h4, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{32'h0000_0F0F, 5, 1'b0, 4'h4, 32'h0,         4'h0, 32'h0000_0F0F});
        vecs.push_back('{32'h0000_0F0F, 0, 1'b1, 4'h4, 32'hFFFF_FFFF, 4'h1, 32'h0});
        vecs.push_back('{32'h0000_0F0F, 0, 1'b0, 4'h4, 32'h0,         4'h0, 32'h0000_0F00});
        vecs.push_back('{32'h0000_0F0F, 0, 1'b1, 4'h0, 32'h0000_0000, 4'hF, 32'h0});
        vecs.push_back('{32'h0000_0F0F, 0, 1'b0, 4'h0, 32'h0,         4'h0, 32'h0000_0F0F});
        vecs.push_back('{32'h0000_0F0F, 0, 1'b1, 4'h4, 32'h0000_0F00, 4'h1, 32'h0});
        vecs.push_back('{32'h0000_0F0F, 0, 1'b0, 4'h4, 32'h0,         4'h0, 32'h0000_0F00});
        vecs.push_back('{32'h0000_0F0F, 0, 1'b1, 4'h4, 32'hFFFF_FFFF, 4'h2, 32'h0});
        vecs.push_back('{32'h0000_0F0F, 0, 1'b0, 4'h4, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{32'h0000_0F0F, 0, 1'b0, 4'hC, 32'h0,         4'h0, 32'h0000_0000});
        vecs.push_back('{32'h0000_0F0F, 0, 1'b0, 4'h8, 32'h0,         4'h0, 32'h0000_0000});

        // Reset with all pins high, then let the priming window expire.
        wait_cycles(3);
        checkOutput("reset rdata", rdata, 32'h0);
        checkOutput("reset ready", {31'h0, ready}, 32'h0);
        checkOutput("reset irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_cycles(10);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(i, vecs[i]);
        end

        // A rising edge landing on the same clock as its W1C must survive.
        io = 32'h0;
        wait_cycles(5);
        bus_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
        bus_write(BASE + 32'h4, 32'hFFFF_FFFF, 4'hF);
        read_check("pre-edge rise", 4'h4, 32'h0);
        @(negedge clk);
        io = 32'h0000_0008;
        @(negedge clk);
        bus_write(BASE + 32'h4, 32'h0000_0008, 4'hF);
        read_check("edge vs w1c", 4'h4, 32'h0000_0008);

        // Read and write together: read sees the pre-clear value, one ready pulse.
        bus_rw(BASE + 32'h4, 32'h0000_0008, 4'hF, d, r);
        checkOutput("rw rdata", d, 32'h0000_0008);
        checkOutput("rw ready", {31'h0, r}, 32'h1);
        @(negedge clk);
        checkOutput("rw ready low", {31'h0, ready}, 32'h0);
        read_check("rw cleared", 4'h4, 32'h0);

        // Inactive window leaves rdata and ready alone; active read is one cycle wide.
        read_check("data bit3", 4'h0, 32'h0000_0008);
        @(negedge clk);
        addr = BASE + 32'h20;
        ren  = 1'b1;
        #1;
        checkOutput("inactive active", {31'h0, active}, 32'h0);
        @(negedge clk);
        ren = 1'b0;
        checkOutput("inactive ready", {31'h0, ready}, 32'h0);
        checkOutput("inactive rdata", rdata, 32'h0000_0008);
        addr = BASE;
        ren  = 1'b1;
        #1;
        checkOutput("base active", {31'h0, active}, 32'h1);
        @(negedge clk);
        ren = 1'b0;
        checkOutput("active ready", {31'h0, ready}, 32'h1);
        @(negedge clk);
        checkOutput("ready width", {31'h0, ready}, 32'h0);

        // Interrupt behaviour.
        io = 32'h0;
        wait_cycles(5);
        bus_write(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
        bus_write(BASE + 32'h4, 32'hFFFF_FFFF, 4'hF);
`ifdef PARALLEL_INPUT_IRQ_EN
        bus_write(BASE + 32'hC, 32'h0000_0080, 4'hF);
        read_check("irq_en readback", 4'hC, 32'h0000_0080);
        checkOutput("irq idle", {31'h0, irq}, 32'h0);
        io = 32'h0000_0080;
        wait_cycles(5);
        checkOutput("irq set", {31'h0, irq}, 32'h1);
        bus_write(BASE + 32'h4, 32'h0000_0080, 4'hF);
        checkOutput("irq lag", {31'h0, irq}, 32'h1);
        @(negedge clk);
        checkOutput("irq cleared", {31'h0, irq}, 32'h0);
`else
        bus_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
        read_check("irq_en absent", 4'hC, 32'h0);
        io = 32'h0000_0080;
        wait_cycles(5);
        checkOutput("irq tied low", {31'h0, irq}, 32'h0);
        read_check("rise bit7", 4'h4, 32'h0000_0080);
`endif

        // Reset during a read drops it and clears rdata; pins high through reset stay quiet.
        read_check("data bit7", 4'h0, 32'h0000_0080);
        @(negedge clk);
        addr = BASE;
        ren  = 1'b1;
        rst  = 1'b1;
        io   = 32'hFFFF_FFFF;
        @(negedge clk);
        ren = 1'b0;
        checkOutput("midreset ready", {31'h0, ready}, 32'h0);
        checkOutput("midreset rdata", rdata, 32'h0);
        checkOutput("midreset irq", {31'h0, irq}, 32'h0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(10);
        read_check("post-reset rise", 4'h4, 32'h0);
        read_check("post-reset fall", 4'h8, 32'h0);
        read_check("post-reset data", 4'h0, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
